pwm_top_level: RTL and testbench

- Four-channel PWM controller with an internal command path: SPI master instance (`spi_master`) → internal SPI slave → command FIFO → round-robin dispatcher → four PWM generators.
- Each 16-bit command word is {duty[15:8], period[7:0]}. Values are in clk cycles.
- Top-level pins are only clock, reset and the four PWM outputs. Commands are injected at the internal `spi_master` transmit interface.

---
 rtl/pwm_top_level.sv | 252 +++++++++++++++++++++++++
 tb/tb_pwm_top_level.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_top_level.sv
// pwm_top_level: SPI-fed command FIFO dispatching {duty,period} words round-robin to four PWM channels.
// The command source is the transmit interface of the internal spi_master instance.

module pwm_spi_master #(
    parameter int DATA_W            = 16,
    parameter int CLKS_PER_HALF_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_data_valid,
    output logic              o_tx_ready,
    output logic              sclk_o,
    output logic              cs_n_o,
    output logic              mosi_o
);
    localparam int HW = CLKS_PER_HALF_BIT > 1 ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam int BW = $clog2(DATA_W);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [HW-1:0]     hcnt_q, hcnt_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              sclk_q, sclk_d, cs_n_q, cs_n_d, half_end;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            hcnt_q  <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            hcnt_q  <= hcnt_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
        end
    end
    assign half_end = hcnt_q == HW'(CLKS_PER_HALF_BIT - 1);
    // MOSI is the shift register MSB, so it only moves when the register shifts on a falling SCLK edge
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        hcnt_d  = hcnt_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        case (state_q)
            IDLE: if (i_tx_data_valid) begin
                shreg_d = i_tx_data;
                state_d = LOAD;
            end
            LOAD: begin
                cs_n_d  = 1'b0;
                sclk_d  = 1'b0;
                hcnt_d  = '0;
                bit_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                hcnt_d = half_end ? '0 : hcnt_q + 1'b1;
                if (half_end) begin
                    sclk_d = ~sclk_q;
                    if (sclk_q && bit_q == BW'(DATA_W - 1)) begin
                        cs_n_d  = 1'b1;
                        state_d = DONE;
                    end else if (sclk_q) begin
                        bit_d   = bit_q + 1'b1;
                        shreg_d = shreg_q << 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign o_tx_ready = state_q == IDLE;
    assign sclk_o     = sclk_q;
    assign cs_n_o     = cs_n_q;
    assign mosi_o     = shreg_q[DATA_W-1];
endmodule

module pwm_spi_slave #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic [DATA_W-1:0] word_o,
    output logic              word_valid_o
);
    localparam int CW = $clog2(DATA_W + 1);
    logic              sclk_prev_q, cs_prev_q, valid_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] word_q;
    // only a complete word closed by CS_n rising is delivered; anything shorter is discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            valid_q     <= 1'b0;
            cnt_q       <= '0;
            word_q      <= '0;
        end else begin
            sclk_prev_q <= sclk_i;
            cs_prev_q   <= cs_n_i;
            valid_q     <= cs_n_i && !cs_prev_q && cnt_q == CW'(DATA_W);
            if (cs_n_i) begin
                cnt_q <= '0;
            end else if (sclk_i && !sclk_prev_q) begin
                word_q <= {word_q[DATA_W-2:0], mosi_i};
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end
    assign word_o       = word_q;
    assign word_valid_o = valid_q;
endmodule

module pwm_cmd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              empty_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_q, rd_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, full, do_push, do_pop;
    assign empty_o = wr_q == rd_q;
    assign full    = wr_q[AW] != rd_q[AW] && wr_q[AW-1:0] == rd_q[AW-1:0];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr_q    <= wr_q + (AW + 1)'(do_push);
            rd_q    <= rd_q + (AW + 1)'(do_pop);
            valid_q <= do_pop;
            if (do_pop) data_q <= mem_q[rd_q[AW-1:0]];
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end
    assign data_o  = data_q;
    assign valid_o = valid_q;
endmodule

module pwm_channel (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [15:0] cfg_i,
    output logic        pwm_o
);
    logic [7:0] duty_q, duty_d, period_q, period_d, cnt_q, cnt_d, pduty_q, pperiod_q;
    logic       pend_q, pwm_q, at_end, apply;
    // a staged config only lands where the counter restarts, so no pulse is ever cut short
    assign at_end = period_q == 8'd0 || cnt_q == period_q - 8'd1;
    assign apply  = pend_q && at_end;
    always_comb begin
        duty_d   = apply ? pduty_q : duty_q;
        period_d = apply ? pperiod_q : period_q;
        cnt_d    = at_end ? 8'd0 : cnt_q + 8'd1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_q    <= '0;
            period_q  <= '0;
            cnt_q     <= '0;
            pduty_q   <= '0;
            pperiod_q <= '0;
            pend_q    <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            duty_q   <= duty_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            pwm_q    <= period_d != 8'd0 && cnt_d < duty_d;
            pend_q   <= load_i || (pend_q && !apply);
            if (load_i) {pduty_q, pperiod_q} <= cfg_i;
        end
    end
    assign pwm_o = pwm_q;
endmodule

module pwm_top_level #(
    parameter int DATA_W            = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int CLKS_PER_HALF_BIT = 1,
    parameter int NUM_CH            = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pwm_out_0,
    output logic pwm_out_1,
    output logic pwm_out_2,
    output logic pwm_out_3
);
    logic [DATA_W-1:0] cmd_data, rx_word, fifo_data;
    logic              cmd_valid, sclk, cs_n, mosi, rx_valid;
    logic              fifo_empty, fifo_read_enable, fifo_valid;
    logic [1:0]        ptr_q;
    logic [NUM_CH-1:0] pwm;
    // idle command source; commands are injected at the spi_master transmit interface
    assign cmd_data         = '0;
    assign cmd_valid        = 1'b0;
    assign fifo_read_enable = ~fifo_empty;
    pwm_spi_master #(.DATA_W(DATA_W), .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) spi_master (
        .clk(clk), .rst(rst), .i_tx_data(cmd_data), .i_tx_data_valid(cmd_valid),
        .o_tx_ready(), .sclk_o(sclk), .cs_n_o(cs_n), .mosi_o(mosi)
    );
    pwm_spi_slave #(.DATA_W(DATA_W)) spi_slave (
        .clk(clk), .rst(rst), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
        .word_o(rx_word), .word_valid_o(rx_valid)
    );
    pwm_cmd_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) cmd_fifo (
        .clk(clk), .rst(rst), .push_i(rx_valid), .data_i(rx_word), .pop_i(fifo_read_enable),
        .empty_o(fifo_empty), .data_o(fifo_data), .valid_o(fifo_valid)
    );
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else if (fifo_valid) ptr_q <= ptr_q + 2'd1;
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel u_ch (
            .clk(clk), .rst(rst), .load_i(fifo_valid && ptr_q == 2'(g)),
            .cfg_i(fifo_data), .pwm_o(pwm[g])
        );
    end
    assign pwm_out_0 = pwm[0];
    assign pwm_out_1 = pwm[1];
    assign pwm_out_2 = pwm[2];
    assign pwm_out_3 = pwm[3];
endmodule

// File: tb/tb_pwm_top_level.sv
// tb_pwm_top_level: randomized and directed commands checked against a per-channel {duty,period} model.
module tb_pwm_top_level;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_out_0, pwm_out_1, pwm_out_2, pwm_out_3;
    logic [15:0] tx_w;
    int          checks = 0;
    int          errors = 0;
    int          mdl_duty[4];
    int          mdl_per[4];
    int          mdl_ptr = 0;

    pwm_top_level dut (
        .clk(clk), .rst(rst),
        .pwm_out_0(pwm_out_0), .pwm_out_1(pwm_out_1), .pwm_out_2(pwm_out_2), .pwm_out_3(pwm_out_3)
    );

    always #5 clk = ~clk;

    function automatic logic pwm_of(input int ch);
        return ch == 0 ? pwm_out_0 : ch == 1 ? pwm_out_1 : ch == 2 ? pwm_out_2 : pwm_out_3;
    endfunction

    // observable shape: constant 0 -> (0,0), constant 1 -> (1,0), otherwise (high cycles, period)
    function automatic int exp_hi(input int d, input int p);
        return (p == 0 || d == 0) ? 0 : (d >= p) ? 1 : d;
    endfunction

    function automatic int exp_per(input int d, input int p);
        return (p == 0 || d == 0 || d >= p) ? 0 : p;
    endfunction

    function automatic int model_dispatch(input logic [15:0] w);
        int ch = mdl_ptr;
        mdl_duty[ch] = int'(w[15:8]);
        mdl_per[ch]  = int'(w[7:0]);
        mdl_ptr      = (mdl_ptr + 1) % 4;
        return ch;
    endfunction

    task automatic model_reset();
        mdl_ptr = 0;
        for (int i = 0; i < 4; i++) begin
            mdl_duty[i] = 0;
            mdl_per[i]  = 0;
        end
    endtask

    task automatic send(input logic [15:0] w);
        int t = 0;
        while (dut.spi_master.o_tx_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL send_ready_timeout: o_tx_ready=%b after %0d cycles, required 1", dut.spi_master.o_tx_ready, t);
        end
        tx_w = w;
        force dut.spi_master.i_tx_data = tx_w;
        force dut.spi_master.i_tx_data_valid = 1'b1;
        @(negedge clk);
        force dut.spi_master.i_tx_data_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure(input int ch, output int hi, output int per);
        int t = 0;
        int lo = 0;
        hi = 0;
        while (pwm_of(ch) !== 1'b0 && t < 600) begin @(negedge clk); t++; end
        while (pwm_of(ch) !== 1'b1 && t < 600) begin @(negedge clk); t++; end
        while (pwm_of(ch) === 1'b1 && t < 600) begin @(negedge clk); t++; hi++; end
        while (pwm_of(ch) === 1'b0 && t < 600) begin @(negedge clk); t++; lo++; end
        per = (t < 600) ? hi + lo : -1;
    endtask

    task automatic observe(input int ch, output int hi, output int per);
        int ones = 0;
        repeat (100) begin
            @(negedge clk);
            if (pwm_of(ch) === 1'b1) ones++;
        end
        if (ones == 0) begin
            hi = 0;
            per = 0;
        end else if (ones == 100) begin
            hi = 1;
            per = 0;
        end else begin
            measure(ch, hi, per);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({pwm_out_3, pwm_out_2, pwm_out_1, pwm_out_0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pwm: got %b, required 0000", {pwm_out_3, pwm_out_2, pwm_out_1, pwm_out_0});
        end
        checks++;
        if (dut.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo_empty: got %b, required 1", dut.fifo_empty);
        end
        checks++;
        if (dut.spi_master.o_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx_ready: got %b, required 1", dut.spi_master.o_tx_ready);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ({pwm_out_3, pwm_out_2, pwm_out_1, pwm_out_0} !== 4'b0000 || dut.fifo_empty !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_idle_200: %0d non-idle samples, required 0", bad);
        end
    endtask

    task automatic test_directed();
        logic [15:0] words[4] = '{16'h0A1E, 16'h140A, 16'h1E14, 16'h0204};
        int t = 0;
        int bad = 0;
        int ch, hi, per;
        send(words[0]);
        ch = model_dispatch(words[0]);
        while (pwm_out_0 !== 1'b1 && t < 60) begin @(negedge clk); t++; end
        checks++;
        if (t > 40) begin
            errors++;
            $display("FAIL first_pulse_latency: %0d cycles, required <= 40", t);
        end
        measure(0, hi, per);
        checks++;
        if (hi !== 10 || per !== 30) begin
            errors++;
            $display("FAIL ch0_0A1E: high=%0d period=%0d, required high=10 period=30", hi, per);
        end
        repeat (100) begin
            @(negedge clk);
            if ({pwm_out_3, pwm_out_2, pwm_out_1} !== 3'b000) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL ch123_idle: %0d high samples, required 0", bad);
        end
        for (int i = 1; i < 4; i++) begin
            send(words[i]);
            ch = model_dispatch(words[i]);
            wait_cycles(50);
            observe(ch, hi, per);
            checks++;
            if (hi !== exp_hi(mdl_duty[ch], mdl_per[ch]) || per !== exp_per(mdl_duty[ch], mdl_per[ch])) begin
                errors++;
                $display("FAIL directed_ch%0d word %h: high=%0d period=%0d, required high=%0d period=%0d", ch, words[i], hi, per,
                         exp_hi(mdl_duty[ch], mdl_per[ch]), exp_per(mdl_duty[ch], mdl_per[ch]));
            end
        end
        measure(0, hi, per);
        checks++;
        if (hi !== 10 || per !== 30) begin
            errors++;
            $display("FAIL ch0_unchanged: high=%0d period=%0d, required high=10 period=30", hi, per);
        end
    endtask

    task automatic test_period_boundary();
        int run = 0;
        int bad = 0;
        int pulses = 0;
        int ones = 0;
        bit partial;
        int ch;
        send(16'h0000);
        ch = model_dispatch(16'h0000);
        partial = pwm_out_0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (pwm_out_0 === 1'b1) begin
                run++;
            end else begin
                if (run != 0 && !partial) begin
                    pulses++;
                    if (run != 10) bad++;
                end
                run = 0;
                partial = 1'b0;
            end
        end
        checks++;
        if (bad != 0 || run != 0 || ch != 0) begin
            errors++;
            $display("FAIL ch0_stop_boundary: %0d truncated pulses of %0d, open run %0d, channel %0d, required 0/-/0/0", bad, pulses, run, ch);
        end
        repeat (100) begin
            @(negedge clk);
            if (pwm_out_0 === 1'b1) ones++;
        end
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL ch0_stays_low: %0d high samples, required 0", ones);
        end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int ch, prev, hi, per;
        for (int i = 0; i < 12; i++) begin
            w = {8'(int'($urandom_range(45, 0))), 8'(int'($urandom_range(40, 0)))};
            prev = mdl_per[mdl_ptr];
            send(w);
            ch = model_dispatch(w);
            wait_cycles(45 + 2 * prev);
            observe(ch, hi, per);
            checks++;
            if (hi !== exp_hi(mdl_duty[ch], mdl_per[ch]) || per !== exp_per(mdl_duty[ch], mdl_per[ch])) begin
                errors++;
                $display("FAIL random_%0d ch%0d word %h: high=%0d period=%0d, required high=%0d period=%0d", i, ch, w, hi, per,
                         exp_hi(mdl_duty[ch], mdl_per[ch]), exp_per(mdl_duty[ch], mdl_per[ch]));
            end
        end
    endtask

    task automatic test_busy_ignored();
        logic [15:0] a, b, c;
        int ch_a, ch_c, hi, per;
        a = {8'd3, 8'd7};
        b = {8'd9, 8'd37};
        c = {8'(int'($urandom_range(10, 1))), 8'(int'($urandom_range(22, 12)))};
        send(a);
        ch_a = model_dispatch(a);
        wait_cycles(5);
        checks++;
        if (dut.spi_master.o_tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_tx_ready: got %b, required 0", dut.spi_master.o_tx_ready);
        end
        tx_w = b;
        force dut.spi_master.i_tx_data = tx_w;
        force dut.spi_master.i_tx_data_valid = 1'b1;
        @(negedge clk);
        force dut.spi_master.i_tx_data_valid = 1'b0;
        send(c);
        ch_c = model_dispatch(c);
        wait_cycles(130);
        observe(ch_a, hi, per);
        checks++;
        if (hi !== 3 || per !== 7) begin
            errors++;
            $display("FAIL busy_first_word ch%0d: high=%0d period=%0d, required high=3 period=7", ch_a, hi, per);
        end
        observe(ch_c, hi, per);
        checks++;
        if (hi !== exp_hi(mdl_duty[ch_c], mdl_per[ch_c]) || per !== exp_per(mdl_duty[ch_c], mdl_per[ch_c])) begin
            errors++;
            $display("FAIL busy_next_word ch%0d: high=%0d period=%0d, required high=%0d period=%0d", ch_c, hi, per,
                     exp_hi(mdl_duty[ch_c], mdl_per[ch_c]), exp_per(mdl_duty[ch_c], mdl_per[ch_c]));
        end
    endtask

    task automatic test_overflow();
        logic [15:0] q[$];
        logic [15:0] w;
        int ch, p, hi, per;
        force dut.fifo_read_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            p = (i < 8) ? int'($urandom_range(20, 4)) : int'($urandom_range(30, 21));
            w = {8'(int'($urandom_range(p - 1, 1))), 8'(p)};
            send(w);
            if (q.size() < 8) q.push_back(w);
        end
        wait_cycles(50);
        checks++;
        if (dut.fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL overflow_held: fifo_empty=%b, required 0", dut.fifo_empty);
        end
        release dut.fifo_read_enable;
        while (q.size() != 0) ch = model_dispatch(q.pop_front());
        wait_cycles(170);
        checks++;
        if (dut.fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL overflow_drained: fifo_empty=%b, required 1", dut.fifo_empty);
        end
        for (int c = 0; c < 4; c++) begin
            observe(c, hi, per);
            checks++;
            if (hi !== exp_hi(mdl_duty[c], mdl_per[c]) || per !== exp_per(mdl_duty[c], mdl_per[c])) begin
                errors++;
                $display("FAIL overflow_ch%0d: high=%0d period=%0d, required high=%0d period=%0d", c, hi, per,
                         exp_hi(mdl_duty[c], mdl_per[c]), exp_per(mdl_duty[c], mdl_per[c]));
            end
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int hi, per, ch;
        send(16'h0507);
        wait_cycles(15);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({pwm_out_3, pwm_out_2, pwm_out_1, pwm_out_0} !== 4'b0000 || dut.fifo_empty !== 1'b1 ||
            dut.spi_master.o_tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_state: pwm=%b empty=%b ready=%b, required 0000/1/1",
                     {pwm_out_3, pwm_out_2, pwm_out_1, pwm_out_0}, dut.fifo_empty, dut.spi_master.o_tx_ready);
        end
        repeat (80) begin
            @(negedge clk);
            if ({pwm_out_3, pwm_out_2, pwm_out_1, pwm_out_0} !== 4'b0000 || dut.fifo_empty !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midreset_no_push: %0d non-idle samples, required 0", bad);
        end
        send(16'h0306);
        ch = model_dispatch(16'h0306);
        wait_cycles(50);
        observe(ch, hi, per);
        checks++;
        if (ch != 0 || hi !== 3 || per !== 6) begin
            errors++;
            $display("FAIL midreset_ptr ch%0d: high=%0d period=%0d, required ch0 high=3 period=6", ch, hi, per);
        end
    endtask

    initial begin
        tx_w = '0;
        test_reset();
        test_directed();
        test_period_boundary();
        test_random();
        test_busy_ignored();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
